// File: rtl/servo_pkg.sv
// Shared types and constants for the servo angle ramp block.
// Slew limiting is enabled by the SERVO_RAMP_SLEW_EN macro (see servo_slew_step).
package servo_pkg;

  typedef logic [7:0] angle_t;

  localparam angle_t ANGLE_MAX        = 8'd180;
  localparam angle_t ANGLE_CENTRE     = 8'd90;
  localparam int     FRAME_CYCLES_50M = 1000000;

  typedef enum logic [1:0] {
    COUNT,
    UPDATE,
    LOAD
  } ramp_state_t;

endpackage

// File: rtl/servo_slew_step.sv
// Next-angle computation for one servo: move current toward target.
// Macro SERVO_RAMP_SLEW_EN: defined = limit each move to STEP_MAX, undefined = jump to target.
module servo_slew_step
  import servo_pkg::*;
#(
  parameter int STEP_MAX = 2
) (
  input  logic [7:0] cur,
  input  logic [7:0] tgt,
  output logic [7:0] nxt
);

`ifdef SERVO_RAMP_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  // Without slew limiting the step bound exceeds any possible 9-bit difference,
  // so the same datapath always lands on the target.
  localparam int                 STEP_EFF = SLEW_EN ? STEP_MAX : 255;
  localparam logic signed [9:0]  STEP_S   = 10'(STEP_EFF);
  localparam logic        [7:0]  STEP_U   = 8'(STEP_EFF);

  logic signed [8:0] diff;
  logic signed [9:0] diff_x;

  assign diff   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
  assign diff_x = {diff[8], diff};

  always_comb begin
    nxt = tgt;
    if (diff_x > STEP_S) begin
      nxt = cur + STEP_U;
    end else if (diff_x < -STEP_S) begin
      nxt = cur - STEP_U;
    end
  end

endmodule

// File: rtl/servo_angle_ramp.sv
// Four-servo angle ramp: accepts target writes and steps the commanded angles once per frame.
// Slew limiting is controlled by SERVO_RAMP_SLEW_EN (inside servo_slew_step).
module servo_angle_ramp
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_50M,
  parameter int STEP_MAX     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic [1:0] tgt_sel,
  input  logic [7:0] tgt_angle,
  output logic [7:0] angle1,
  output logic [7:0] angle2,
  output logic [7:0] angle3,
  output logic [7:0] angle4,
  output logic       nextangle,
  output logic       busy
);

  localparam logic [19:0] CNT_LAST = 20'(FRAME_CYCLES - 1);

  ramp_state_t state;
  logic [19:0] cnt;
  angle_t      cur [4];
  angle_t      tgt [4];
  angle_t      nxt [4];
  logic        any_diff;

  function automatic angle_t clamp_angle(input logic [7:0] a);
    return (a > ANGLE_MAX) ? ANGLE_MAX : a;
  endfunction

  assign angle1 = cur[0];
  assign angle2 = cur[1];
  assign angle3 = cur[2];
  assign angle4 = cur[3];

  for (genvar g = 0; g < 4; g++) begin : g_slew
    servo_slew_step #(
      .STEP_MAX(STEP_MAX)
    ) u_step (
      .cur(cur[g]),
      .tgt(tgt[g]),
      .nxt(nxt[g])
    );
  end

  always_comb begin
    any_diff = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cur[i] != tgt[i]) any_diff = 1'b1;
    end
  end

  // Reset parks the FSM in UPDATE with the counter at 0, i.e. exactly where a
  // frame wrap leaves it, so the first edge after release enters LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UPDATE;
      cnt       <= '0;
      busy      <= 1'b0;
      tgt_ready <= 1'b0;
      nextangle <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cur[i] <= ANGLE_CENTRE;
        tgt[i] <= ANGLE_CENTRE;
      end
    end else begin
      cnt       <= (cnt == CNT_LAST) ? '0 : cnt + 20'd1;
      busy      <= any_diff;
      nextangle <= 1'b0;

      case (state)
        COUNT: begin
          if (cnt == CNT_LAST) begin
            state     <= UPDATE;
            tgt_ready <= 1'b0;
          end
        end
        UPDATE: begin
          for (int i = 0; i < 4; i++) begin
            cur[i] <= nxt[i];
          end
          state     <= LOAD;
          nextangle <= 1'b1;
          tgt_ready <= 1'b1;
        end
        LOAD: begin
          state <= COUNT;
        end
        default: begin
          state <= COUNT;
        end
      endcase

      // tgt_ready is low throughout UPDATE, so the step never races a write.
      if (tgt_valid && tgt_ready) begin
        tgt[tgt_sel] <= clamp_angle(tgt_angle);
      end
    end
  end

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Scoreboard bench for servo_angle_ramp (FRAME_CYCLES=100, STEP_MAX=2); follows SERVO_RAMP_SLEW_EN.
module tb_servo_angle_ramp;

  localparam int FC = 100;
  localparam int SM = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic [1:0] tgt_sel = 2'd0;
  logic [7:0] tgt_angle = 8'd0;
  logic [7:0] angle1, angle2, angle3, angle4;
  logic       nextangle;
  logic       busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          last_pulse = 0;
  bit          have_last = 1'b0;
  logic [7:0]  m_cur [4];
  logic [7:0]  m_tgt [4];

  servo_angle_ramp #(
    .FRAME_CYCLES(FC),
    .STEP_MAX(SM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt_sel(tgt_sel),
    .tgt_angle(tgt_angle),
    .angle1(angle1),
    .angle2(angle2),
    .angle3(angle3),
    .angle4(angle4),
    .nextangle(nextangle),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] clampm(input logic [7:0] a);
    return (a > 8'd180) ? 8'd180 : a;
  endfunction

  function automatic logic [7:0] stepm(input logic [7:0] c, input logic [7:0] t);
`ifdef SERVO_RAMP_SLEW_EN
    int d;
    d = int'(t) - int'(c);
    if (d > SM) return c + 8'(SM);
    if (d < -SM) return c - 8'(SM);
    return t;
`else
    return (c == t) ? c : t;
`endif
  endfunction

  function automatic logic m_busy();
    for (int i = 0; i < 4; i++) begin
      if (m_cur[i] != m_tgt[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Monitor: every nextangle pulse consumes one expected angle set.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        have_last = 1'b0;
      end else if (nextangle) begin
        if (exp_q.size() == 0) chk("sb_unexpected_pulse", 32'd1, 32'd0);
        else chk("angles", {angle1, angle2, angle3, angle4}, exp_q.pop_front());
        if (have_last) chk("period", 32'(cyc - last_pulse), 32'(FC));
        last_pulse = cyc;
        have_last  = 1'b1;
      end
    end
  end

  task automatic push_exp();
    for (int i = 0; i < 4; i++) m_cur[i] = stepm(m_cur[i], m_tgt[i]);
    exp_q.push_back({m_cur[0], m_cur[1], m_cur[2], m_cur[3]});
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!nextangle && n < 3 * FC);
    chk("pulse_seen", 32'(nextangle), 32'd1);
  endtask

  task automatic frame_end();
    int n;
    push_exp();
    wait_pulse(n);
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_busy()));
    chk("na_width", 32'(nextangle), 32'd0);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] ang);
    int n;
    @(negedge clk);
    tgt_sel   = sel;
    tgt_angle = ang;
    tgt_valid = 1'b1;
    n = 0;
    while (!tgt_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wr_accept", 32'(tgt_ready), 32'd1);
    @(negedge clk);
    tgt_valid = 1'b0;
    m_tgt[sel] = clampm(ang);
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    rst = 1'b1;
    tgt_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_angles", {angle1, angle2, angle3, angle4}, 32'h5A5A5A5A);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(tgt_ready), 32'd0);
    chk("rst_na", 32'(nextangle), 32'd0);
    for (int i = 0; i < 4; i++) begin
      m_cur[i] = 8'd90;
      m_tgt[i] = 8'd90;
    end
    exp_q.push_back(32'h5A5A5A5A);
    rst = 1'b0;
    wait_pulse(n);
    chk("rel_latency", 32'(n), 32'd1);
    @(negedge clk);
    chk("rel_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    do_reset();

    // Single servo ramp to 95
    wr(2'd0, 8'd95);
    repeat (3) frame_end();

    // Clamp above 180, ramp to the limit and stay
    wr(2'd2, 8'd250);
    k = 0;
    while (m_cur[2] != 8'd180 && k < 60) begin
      frame_end();
      k++;
    end
    frame_end();
    frame_end();

    // Last write in a frame wins
    wr(2'd1, 8'd0);
    wr(2'd1, 8'd91);
    frame_end();
    frame_end();

    // Write held across UPDATE is accepted in LOAD and applies next frame
    chk("ready_count", 32'(tgt_ready), 32'd1);
    push_exp();
    k = 0;
    while (tgt_ready && k < 2 * FC) begin
      @(negedge clk);
      k++;
    end
    chk("ready_upd_low", 32'(tgt_ready), 32'd0);
    chk("na_upd_low", 32'(nextangle), 32'd0);
    tgt_sel   = 2'd3;
    tgt_angle = 8'd100;
    tgt_valid = 1'b1;
    @(negedge clk);
    chk("ready_load", 32'(tgt_ready), 32'd1);
    chk("na_load", 32'(nextangle), 32'd1);
    @(negedge clk);
    tgt_valid = 1'b0;
    m_tgt[3] = 8'd100;
    frame_end();

    // Reset mid-ramp discards targets, then a fresh write
    wr(2'd0, 8'd170);
    frame_end();
    wr(2'd1, 8'd10);
    repeat (20) @(negedge clk);
    do_reset();
    frame_end();
    wr(2'd0, 8'd170);
    frame_end();

    repeat (5) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/servo_angle_ramp.md
SERVO_ANGLE_RAMP -- requirements
Module: servo_angle_ramp

Interface
REQ-001 Parameter FRAME_CYCLES, default 1000000, clk cycles per servo frame (20 ms at 50 MHz).
REQ-002 Parameter STEP_MAX, default 2, maximum degrees moved per servo per frame.
REQ-003 clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tgt_valid  input  1  target-write request.
REQ-006 tgt_ready  output  1  target-write accept; a write occurs when tgt_valid and tgt_ready are both high.
REQ-007 tgt_sel  input  2  servo index, 0..3, maps to angle1..angle4.
REQ-008 tgt_angle  input  8  requested angle in degrees.
REQ-009 angle1, angle2, angle3, angle4  output  8 each  current commanded angles for the downstream PWM stage.
REQ-010 nextangle  output  1  one-cycle load strobe to the PWM stage; angle1..4 are stable whenever it is high.
REQ-011 busy  output  1  high while any current angle differs from its target.

Function
REQ-012 The frame counter SHALL be 20 bits, count 0..FRAME_CYCLES-1, and wrap to 0.
REQ-013 The FSM SHALL have three states:
- COUNT: counter runs; goes to UPDATE on the cycle the counter wraps.
- UPDATE: lasts 1 cycle; goes to LOAD.
- LOAD: lasts 1 cycle; goes to COUNT.
REQ-014 In UPDATE, each current angle SHALL move toward its target by min(|target-current|, STEP_MAX).
REQ-015 The difference SHALL be computed in 9-bit signed arithmetic, with no overshoot.
REQ-016 nextangle SHALL be high exactly in LOAD, once per frame, even when no angle changed.
REQ-017 tgt_ready SHALL be low in UPDATE and high in COUNT and LOAD.
REQ-018 Writes presented during UPDATE SHALL be neither accepted nor lost; the requester holds them.
REQ-019 An accepted tgt_angle above 180 SHALL be clamped to 180.
REQ-020 Multiple writes to the same servo within one frame: the last accepted value wins.
REQ-021 Write latency: a target accepted in frame N first affects the angles at the UPDATE ending frame N.
REQ-022 A write accepted in LOAD SHALL apply at the next frame's UPDATE.
REQ-023 busy SHALL be registered and updated every cycle from the current/target compare.
REQ-024 The counter SHALL keep running during UPDATE and LOAD so the frame period is exactly FRAME_CYCLES.

Reset
REQ-025 While rst is high, the block SHALL set: all current angles and targets = 90, counter = 0, busy = 0, tgt_ready = 0, nextangle = 0.
REQ-026 The FSM SHALL enter LOAD on the first cycle after rst is released, so the downstream stage receives 90 deg.
REQ-027 Asserting rst mid-ramp SHALL discard pending targets; no partial step is applied.

Configuration
REQ-028 Macro SERVO_RAMP_SLEW_EN:
- Defined: angles are slew-limited per REQ-014.
- Undefined: in UPDATE, each current angle SHALL equal its target directly, STEP_MAX is ignored, and busy is 0 after every LOAD.

Structure
REQ-029 Package servo_pkg SHALL hold: angle_t (8-bit logic), ANGLE_MAX = 180, ANGLE_CENTRE = 90, FRAME_CYCLES_50M = 1000000, and ramp_state_t enum {COUNT, UPDATE, LOAD}.
REQ-030 Sub-module servo_slew_step SHALL be instantiated once per servo; it computes the next angle from current, target and STEP_MAX.

Verification (FRAME_CYCLES = 100, STEP_MAX = 2)
REQ-031 Release rst at cycle 0 -> nextangle high at cycle 1, angle1..4 = 90, busy = 0.
REQ-032 Write servo 0 = 95 -> angle1 steps 92, 94, 95 over three frames; busy falls after the third UPDATE; nextangle period = 100 cycles.
REQ-033 Write servo 2 = 250 -> target clamped to 180; angle3 rises 2 deg per frame and stops at 180.
REQ-034 tgt_valid held during UPDATE -> tgt_ready low that cycle; write accepted in LOAD; angle moves one frame later.
REQ-035 Write servo 1 = 0 then servo 1 = 91 in the same frame -> angle2 goes to 91 and never decreases.
REQ-036 Assert rst during a ramp -> all angles 90 and nextangle pulses on the first cycle after release; repeat with SERVO_RAMP_SLEW_EN undefined -> write 170 gives angle = 170 after one frame.
